// File: rtl/keypad_pkg.sv
// Shared definitions for the hangman keypad path: key codes in the
// {row_onehot, col_onehot} encoding and the debounce state type.
package keypad_pkg;

  // Key code layout. Bit 7..4 = one-hot row (bit 7 = R0), bit 3..0 = one-hot
  // column (bit 3 = C0). Zero means "no key".
  localparam logic [7:0] KEY_NONE          = 8'h00;

  // Letter-group keys on rows R0..R1.
  localparam logic [7:0] KEY_LETTER_0      = 8'h88; // R0 C0
  localparam logic [7:0] KEY_LETTER_1      = 8'h84; // R0 C1
  localparam logic [7:0] KEY_LETTER_2      = 8'h82; // R0 C2
  localparam logic [7:0] KEY_LETTER_3      = 8'h81; // R0 C3
  localparam logic [7:0] KEY_LETTER_4      = 8'h48; // R1 C0
  localparam logic [7:0] KEY_LETTER_5      = 8'h44; // R1 C1
  localparam logic [7:0] KEY_LETTER_6      = 8'h42; // R1 C2
  localparam logic [7:0] KEY_LETTER_7      = 8'h41; // R1 C3

  // Command keys.
  localparam logic [7:0] KEY_SUBMIT_LETTER = 8'h28; // R2 C0
  localparam logic [7:0] KEY_CLEAR         = 8'h24; // R2 C1
  localparam logic [7:0] KEY_SUBMIT_WORD   = 8'h22; // R2 C2
  localparam logic [7:0] KEY_GAME_END      = 8'h21; // R2 C3

  // Keys with no game meaning; the letter FSM ignores them.
  localparam logic [7:0] KEY_INVALID_0     = 8'h18; // R3 C0
  localparam logic [7:0] KEY_INVALID_1     = 8'h14; // R3 C1
  localparam logic [7:0] KEY_INVALID_2     = 8'h12; // R3 C2
  localparam logic [7:0] KEY_INVALID_3     = 8'h11; // R3 C3

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } debounce_state_t;

  // True when exactly one of the four column lines is active.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sampling, per-frame key
// extraction with multi-key rejection, and frame-level debounce producing a
// steady key code plus a one-cycle press strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [7:0] cur_key,
  output logic       strobe
);

  // Dwell counter sized for 0..SCAN_CYCLES-1.
  localparam int DW_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_CYCLES - 1);

  // Debounce counter sized to hold DEBOUNCE_FRAMES; it saturates at all-ones.
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit IMMEDIATE = (DEBOUNCE_FRAMES == 1);

  // ---------------------------------------------------------------------------
  // Column synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] col_sync;

  sync2 #(.WIDTH(4)) u_col_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (col_in),
    .q    (col_sync)
  );

  // ---------------------------------------------------------------------------
  // Row scan
  // ---------------------------------------------------------------------------
  logic [DW_W-1:0] dwell_q;
  logic [1:0]      row_idx_q;
  logic            sample;
  logic            frame_end;

  // Row index 0 drives R0, which is bit 3 of the port.
  assign row_out   = 4'b1000 >> row_idx_q;
  assign sample    = (dwell_q == DWELL_LAST);
  assign frame_end = sample && (row_idx_q == 2'd3);

  // Dwell counter and row rotation; the row advances after its last dwell cycle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      dwell_q   <= '0;
      row_idx_q <= 2'd0;
    end else if (sample) begin
      dwell_q   <= '0;
      row_idx_q <= row_idx_q + 2'd1;
    end else begin
      dwell_q   <= dwell_q + DW_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame accumulation
  // ---------------------------------------------------------------------------
  logic [7:0] hit_q;
  logic       multi_q;
  logic [7:0] hit_d;
  logic       multi_d;
  logic [7:0] frame_q;
  logic       frame_valid_q;

  // Fold the current row's sample into the frame's hit / multi-key status.
  always_comb begin
    hit_d   = hit_q;
    multi_d = multi_q;
    if (sample && (col_sync != 4'b0000)) begin
      if (is_onehot4(col_sync) && (hit_q == KEY_NONE)) begin
        hit_d = {row_out, col_sync};
      end else begin
        multi_d = 1'b1;
      end
    end
  end

  // Hold per-frame status; at the R3 sample publish the frame result for one cycle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hit_q         <= KEY_NONE;
      multi_q       <= 1'b0;
      frame_q       <= KEY_NONE;
      frame_valid_q <= 1'b0;
    end else if (frame_end) begin
      hit_q         <= KEY_NONE;
      multi_q       <= 1'b0;
      frame_q       <= multi_d ? KEY_NONE : hit_d;
      frame_valid_q <= 1'b1;
    end else begin
      hit_q         <= hit_d;
      multi_q       <= multi_d;
      frame_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       cand_q, cand_d;
  logic [7:0]       key_q, key_d;
  logic             strobe_q, strobe_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

  // State, counter and output registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= KEY_NONE;
      key_q    <= KEY_NONE;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
    end
  end

  // Next state: advanced only on a published frame result; strobe is a single pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    key_d    = key_q;
    strobe_d = 1'b0;
    if (frame_valid_q) begin
      case (state_q)
        IDLE: begin
          if (frame_q != KEY_NONE) begin
            cand_d = frame_q;
            cnt_d  = CNT_ONE;
            if (IMMEDIATE) begin
              key_d    = frame_q;
              strobe_d = 1'b1;
              state_d  = PRESSED;
            end else begin
              state_d  = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (frame_q == KEY_NONE) begin
            state_d = IDLE;
          end else if (frame_q == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TARGET) begin
              key_d    = cand_q;
              strobe_d = 1'b1;
              state_d  = PRESSED;
            end
          end else begin
            cand_d = frame_q;
            cnt_d  = CNT_ONE;
          end
        end
        PRESSED: begin
          if (frame_q != key_q) begin
            cnt_d = CNT_ONE;
            if (IMMEDIATE) begin
              key_d   = KEY_NONE;
              state_d = IDLE;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (frame_q == key_q) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TARGET) begin
              key_d   = KEY_NONE;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign cur_key = key_q;
  assign strobe  = strobe_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Upstream stage of the hangman keypad path. Drives the 4x4 matrix keypad rows one at a time, samples the asynchronous column lines, rejects bounce and multi-key presses, and presents one debounced key code with a one-cycle press strobe. Its outputs feed the keypad letter FSM's `cur_key` and `strobe` inputs directly.

## Interface

Parameters:
- `SCAN_CYCLES`, default 1000: clocks each row stays driven; must be >= 4.
- `DEBOUNCE_FRAMES`, default 4: consecutive identical scan frames needed to accept a press or a release; must be >= 1.

Ports:
- `clk`  in  1  system clock.
- `nRst`  in  1  asynchronous active-low reset.
- `col_in`  in  4  raw column lines, active-high; `col_in[3]`=C0 … `col_in[0]`=C3; asynchronous.
- `row_out`  out  4  one-hot row drive, active-high; `row_out[3]`=R0 … `row_out[0]`=R3.
- `cur_key`  out  8  debounced key `{row_onehot, col_onehot}`, same bit order as the ports; 0 = no key. Example: R2 C0 = 8'h28.
- `strobe`  out  1  one-cycle pulse when a new press is accepted.

## Operation

- **Column sync.** `col_in` passes through a 2-flop synchronizer, giving `col_sync`.
- **Row scan.**
  - A dwell counter runs 0..SCAN_CYCLES-1, then the row rotates R0→R1→R2→R3→R0.
  - `row_out` is 4'b1000 after reset.
  - `col_sync` is sampled on the last dwell cycle of each row.
  - One frame = 4 rows = 4·SCAN_CYCLES clocks.
- **Frame accumulation.** For each sampled row:
  - `col_sync`==0: no effect.
  - `col_sync` one-hot and no earlier hit in this frame: record `{row, col}` as the hit.
  - Otherwise (not one-hot, or a second hit): set the multi flag.
  - At the R3 sample, frame result F = multi ? 0 : hit (0 if no hit). Hit and multi flag then clear.
- **Debounce FSM.** Evaluated once per frame result; counter `cnt`, candidate `cand`.
  - IDLE (`cur_key`=0):
    - F≠0: `cand`=F, `cnt`=1, go to CONFIRM.
    - If DEBOUNCE_FRAMES=1, accept immediately, as in CONFIRM.
  - CONFIRM:
    - F==`cand`: `cnt`++. When `cnt`==DEBOUNCE_FRAMES: `cur_key`←`cand`, pulse `strobe`, go to PRESSED.
    - F==0: go to IDLE.
    - Other nonzero F: `cand`=F, `cnt`=1.
  - PRESSED:
    - F==`cur_key`: stay.
    - Otherwise: `cnt`=1, go to RELEASE.
  - RELEASE:
    - F==`cur_key`: go back to PRESSED, no strobe.
    - Otherwise: `cnt`++. When `cnt`==DEBOUNCE_FRAMES: `cur_key`←0, go to IDLE, no strobe.
- **Key change.** Moving directly from key A to key B requires a full release of A, then a full debounce of B. B gets its own strobe.
- **Multi-key.** Two or more simultaneous keys give F=0, treated as no key.
- **Counter width.** `cnt` is wide enough to hold DEBOUNCE_FRAMES and saturates.

## Timing

- **Reset values:**
  - `row_out`=4'b1000
  - `cur_key`=8'h00
  - `strobe`=0
  - FSM=IDLE; dwell counter, `cnt`, `cand`, hit, multi all 0
- **Reset mid-operation.** Takes effect immediately (asynchronous). Scanning restarts at R0, dwell 0, on the first clock after deassertion.
- **Input latency.** `col_in` must be stable at least 2 clocks before the end of a row's dwell to be seen in that row.
- **Output timing.**
  - `cur_key` and `strobe` are registered and change on the clock after the R3 sample.
  - `strobe` is high exactly one cycle, in the same cycle `cur_key` first shows the new code. The consumer may use `strobe & |cur_key`.
- **Press latency.** Key held from the start of frame k → `strobe` one clock after the end of frame k+DEBOUNCE_FRAMES-1.
- **Hold behaviour.** `cur_key` holds steady for the whole PRESSED/RELEASE period. `strobe` never repeats while a key is held.

## Structure

- **Shared package `keypad_pkg`:**
  - Key code localparams (letter keys, submit-letter, clear, submit-word, game-end, invalid keys) in the `{row,col}` encoding, shared with the letter FSM.
  - Debounce state enum `debounce_state_t` {IDLE, CONFIRM, PRESSED, RELEASE}.
- **Sub-module `sync2`:** 2-flop synchronizer with parameterised width, instantiated for `col_in`.

## Test plan

Bench keypad model drives `col_in` from the current `row_out` and the set of held keys. Use SCAN_CYCLES=4 and DEBOUNCE_FRAMES=3, so one frame = 16 clocks.

1. **Reset.** Assert `nRst` → `row_out`=1000, `cur_key`=0, `strobe`=0. After release, `row_out` steps 1000→0100→0010→0001→1000 every 4 clocks.
2. **Clean press and release of R2 C0.**
   - Hold for 6 frames → exactly one `strobe`, with `cur_key`=8'h28, one clock after the 3rd frame end. No further strobe.
   - Release → `cur_key`=0 one clock after the 3rd empty frame. No strobe.
3. **Bounce.** Alternate pressed/released on each frame for 10 frames → `strobe` never asserts, `cur_key` stays 0.
4. **Multi-key.** Hold R0C1 and R1C2 together for 5 frames → F=0, no strobe, `cur_key`=0. Then release R1C2 → strobe with `cur_key`=8'h84 after 3 frames.
5. **Glitch while held.** With 8'h28 accepted, drop the key for 1 frame, then resume → `cur_key` stays 8'h28 throughout, no second strobe.
6. **Reset mid-debounce.** Hold R3C0 for 2 frames, pulse `nRst` → outputs return to reset values. Continued hold yields a strobe (`cur_key`=8'h18) only 3 full frames after reset release.
